formula_pipe_credit_buffer: RTL and testbench

- Output-side buffer and credit controller that sits directly downstream of the fixed-latency formula pipeline (sqrt(a)+sqrt(b)+sqrt(c)).
- The formula pipeline has no stall input, so this block gates argument issue. It allows a new argument set only when a FIFO slot is guaranteed for its result.
- It captures pipeline results into a FIFO and presents them to a ready/valid consumer, so downstream backpressure never drops a result.

---
 rtl/formula_pipe_pkg.sv | 14 +
 rtl/formula_res_fifo.sv | 68 ++++++
 rtl/formula_pipe_credit_buffer.sv | 95 +++++++++
 tb/tb_formula_pipe_credit_buffer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/formula_pipe_pkg.sv
// Shared definitions for the formula pipeline output buffer.
//   RES_W     - width of a formula pipeline result
//   BUF_DEPTH - default number of result buffer entries
//   cnt_w()   - width of a counter able to hold 0..depth inclusive
package formula_pipe_pkg;

  localparam int RES_W     = 32;
  localparam int BUF_DEPTH = 8;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/formula_res_fifo.sv
// Plain synchronous FIFO holding formula pipeline results.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   push_i    - write wdata_i at the tail (caller guarantees not full unless popping)
//   pop_i     - drop the head entry (caller guarantees not empty)
//   wdata_i   - entry to write
//   rdata_o   - head entry, valid while count_o != 0
//   count_o   - current occupancy, 0..DEPTH
// Storage is not reset; only pointers and occupancy are.
module formula_res_fifo
  import formula_pipe_pkg::*;
#(
  parameter int W     = RES_W,
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [W-1:0]              wdata_i,
  output logic [W-1:0]              rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full with a simultaneous pop, wr_ptr equals rd_ptr: the head is read
  // combinationally this cycle and overwritten at the edge, which is safe.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/formula_pipe_credit_buffer.sv
// Output buffer and credit controller behind the fixed-latency formula
// pipeline. The pipeline cannot stall, so an argument set is only issued when
// a FIFO slot is already reserved for its result (count + in_flight < DEPTH).
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   up_vld / up_rdy        - argument source handshake; up_rdy depends on registers only
//   pipe_arg_vld           - pipeline arg_vld, the accepted issue
//   pipe_res_vld, pipe_res - pipeline result
//   down_vld / down_rdy    - consumer handshake, down_data is the FIFO head
//   count                  - FIFO occupancy
//   err                    - sticky: unexpected result or result with no room
module formula_pipe_credit_buffer
  import formula_pipe_pkg::*;
#(
  parameter int W     = RES_W,
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       up_vld,
  output logic                       up_rdy,
  output logic                       pipe_arg_vld,
  input  logic                       pipe_res_vld,
  input  logic [W-1:0]               pipe_res,
  output logic                       down_vld,
  output logic [W-1:0]               down_data,
  input  logic                       down_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int            CW      = cnt_w(DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] fifo_count;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic          err_q, err_d;
  logic [CW:0]   credit_used;
  logic          issue, pop, push, err_cond, res_retire;

  // One extra bit so the sum of the two counters cannot wrap.
  assign credit_used  = {1'b0, fifo_count} + {1'b0, in_flight_q};
  assign up_rdy       = credit_used < DEPTH_X;
  assign issue        = up_vld & up_rdy;
  assign pipe_arg_vld = issue;

  assign down_vld = fifo_count != '0;
  assign pop      = down_vld & down_rdy;

  assign err_cond = pipe_res_vld &
                    ((in_flight_q == '0) | ((fifo_count == DEPTH_C) & ~pop));
  assign push     = pipe_res_vld & ~err_cond;

  // A result only returns a credit if one is outstanding; a spurious result
  // must not underflow the counter.
  assign res_retire = pipe_res_vld & (in_flight_q != '0);

  always_comb begin
    in_flight_d = in_flight_q;
    case ({issue, res_retire})
      2'b10:   in_flight_d = in_flight_q + CW'(1);
      2'b01:   in_flight_d = in_flight_q - CW'(1);
      default: in_flight_d = in_flight_q;
    endcase
    err_d = err_q | err_cond;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_q <= '0;
      err_q       <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
    end
  end

  formula_res_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (pipe_res),
    .rdata_o (down_data),
    .count_o (fifo_count)
  );

  assign count = fifo_count;
  assign err   = err_q;

endmodule

// File: tb/tb_formula_pipe_credit_buffer.sv
// Bench for formula_pipe_credit_buffer: one DEPTH=8 and one DEPTH=4 instance,
// each fed by a 4-cycle delay line standing in for the formula pipeline.
// A queue-based reference model (issued-not-consumed values, landed-result
// count, in-flight count taken from the delay line) is checked every cycle.
module tb_formula_pipe_credit_buffer;
  import formula_pipe_pkg::*;

  localparam int W = RES_W;
  localparam int L = 4;

  logic          clk;
  logic          rst;
  logic          up_vld    [2];
  logic          up_rdy    [2];
  logic          arg_vld   [2];
  logic          res_vld   [2];
  logic [W-1:0]  res       [2];
  logic          down_vld  [2];
  logic [W-1:0]  down_data [2];
  logic          down_rdy  [2];
  logic          err       [2];
  logic [W-1:0]  arg_val   [2];
  logic          inj       [2];
  logic [W-1:0]  inj_data;
  logic [3:0]    count8;
  logic [2:0]    count4;

  logic          dl_v [2][L];
  logic [W-1:0]  dl_d [2][L];

  int            n_tests = 0;
  int            n_fail  = 0;

  int            occ   [2];
  logic [W-1:0]  iss_q [2][$];
  bit            m_err [2];

  bit            smp_rdy [2];
  bit            smp_arg [2];
  bit            smp_dv  [2];
  bit            smp_err [2];
  int            smp_cnt [2];
  logic [W-1:0]  smp_dat [2];
  bit            ev_iss  [2];
  bit            ev_pop  [2];

  formula_pipe_credit_buffer #(.W(W), .DEPTH(8)) u_dut8 (
    .clk          (clk),
    .rst          (rst),
    .up_vld       (up_vld[0]),
    .up_rdy       (up_rdy[0]),
    .pipe_arg_vld (arg_vld[0]),
    .pipe_res_vld (res_vld[0]),
    .pipe_res     (res[0]),
    .down_vld     (down_vld[0]),
    .down_data    (down_data[0]),
    .down_rdy     (down_rdy[0]),
    .count        (count8),
    .err          (err[0])
  );

  formula_pipe_credit_buffer #(.W(W), .DEPTH(4)) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .up_vld       (up_vld[1]),
    .up_rdy       (up_rdy[1]),
    .pipe_arg_vld (arg_vld[1]),
    .pipe_res_vld (res_vld[1]),
    .pipe_res     (res[1]),
    .down_vld     (down_vld[1]),
    .down_data    (down_data[1]),
    .down_rdy     (down_rdy[1]),
    .count        (count4),
    .err          (err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipeline stand-in: the value presented with an issue reappears L cycles later.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int s = 0; s < L; s++) dl_v[k][s] <= 1'b0;
      end else begin
        dl_v[k][0] <= arg_vld[k];
        dl_d[k][0] <= arg_val[k];
        for (int s = 1; s < L; s++) begin
          dl_v[k][s] <= dl_v[k][s-1];
          dl_d[k][s] <= dl_d[k][s-1];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      res_vld[k] = dl_v[k][L-1] | inj[k];
      res[k]     = inj[k] ? inj_data : dl_d[k][L-1];
    end
  end

  function automatic int dep(input int k);
    return (k == 0) ? 8 : 4;
  endfunction

  function automatic int cnt_of(input int k);
    return (k == 0) ? int'(count8) : int'(count4);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [dut%0d]: got %0h, expected %0h", nm, k, act, exp);
    end
  endtask

  // One clock cycle: inputs were set at the preceding negedge. Sample and
  // check against the model, advance the model with this cycle's events,
  // then return at the next negedge.
  task automatic step();
    int infl;
    bit e_rdy, e_vld, arr, ec;
    bit nx_push [2];
    bit nx_err  [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      infl = 0;
      for (int s = 0; s < L; s++) if (dl_v[k][s] === 1'b1) infl++;
      e_rdy = (occ[k] + infl) < dep(k);
      e_vld = occ[k] != 0;
      smp_rdy[k] = up_rdy[k];
      smp_arg[k] = arg_vld[k];
      smp_dv[k]  = down_vld[k];
      smp_err[k] = err[k];
      smp_cnt[k] = cnt_of(k);
      smp_dat[k] = down_data[k];
      if (!rst) begin
        chk("up_rdy", k, up_rdy[k], e_rdy);
        chk("pipe_arg_vld", k, arg_vld[k], up_vld[k] & e_rdy);
        chk("down_vld", k, down_vld[k], e_vld);
        chk("count", k, cnt_of(k), occ[k]);
        chk("err", k, err[k], m_err[k]);
        if (e_vld) chk("down_data", k, down_data[k], iss_q[k][0]);
      end
      ev_iss[k] = up_vld[k] & e_rdy;
      ev_pop[k] = e_vld & down_rdy[k];
      arr = res_vld[k] === 1'b1;
      ec  = arr & ((infl == 0) | ((occ[k] == dep(k)) & !ev_pop[k]));
      nx_push[k] = arr & !ec;
      nx_err[k]  = ec;
      if (ev_iss[k] && !rst) iss_q[k].push_back(arg_val[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        occ[k] = 0;
        iss_q[k].delete();
        m_err[k] = 1'b0;
      end else begin
        occ[k] = occ[k] + int'(nx_push[k]) - int'(ev_pop[k]);
        if (ev_pop[k]) void'(iss_q[k].pop_front());
        if (nx_err[k]) m_err[k] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit          uv;
    bit          dr;
    bit          e_arg;
    bit          e_dv;
    logic [31:0] e_dat;
    int          e_cnt;
  } vec_t;

  initial begin
    vec_t tbl [7];
    int   pulses, pops, issued, drops, maxc, dvn;
    bit   dv4;

    // Single transaction: issue at cycle 0, result lands at 4, visible at 5 only.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 0};
    for (int i = 1; i < 5; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h6, 1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0};

    rst = 1'b1;
    inj_data = 32'hdead_beef;
    for (int k = 0; k < 2; k++) begin
      up_vld[k] = 1'b0; down_rdy[k] = 1'b0; inj[k] = 1'b0; arg_val[k] = '0;
      occ[k] = 0; m_err[k] = 1'b0;
    end
    @(negedge clk);

    // 1. Reset
    step(); step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      chk("rst_up_rdy", k, smp_rdy[k], 1'b1);
      chk("rst_down_vld", k, smp_dv[k], 1'b0);
      chk("rst_count", k, smp_cnt[k], 0);
      chk("rst_err", k, smp_err[k], 1'b0);
    end

    // 2. Single transaction (table driven)
    arg_val[0] = 32'h6;
    for (int i = 0; i < 7; i++) begin
      up_vld[0]   = tbl[i].uv;
      down_rdy[0] = tbl[i].dr;
      step();
      chk($sformatf("single_arg_c%0d", i), 0, smp_arg[0], tbl[i].e_arg);
      chk($sformatf("single_dv_c%0d", i), 0, smp_dv[0], tbl[i].e_dv);
      chk($sformatf("single_cnt_c%0d", i), 0, smp_cnt[0], tbl[i].e_cnt);
      if (tbl[i].e_dv) chk($sformatf("single_dat_c%0d", i), 0, smp_dat[0], tbl[i].e_dat);
    end
    down_rdy[0] = 1'b0;

    // 3. Backpressure fill on the DEPTH=4 instance
    down_rdy[1] = 1'b0;
    up_vld[1]   = 1'b1;
    arg_val[1]  = 32'h100;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (smp_arg[1]) pulses++;
      if (ev_iss[1]) arg_val[1] = arg_val[1] + 1;
    end
    up_vld[1] = 1'b0;
    step();
    chk("fill_pulses", 1, pulses, 4);
    chk("fill_up_rdy", 1, smp_rdy[1], 1'b0);
    chk("fill_count", 1, smp_cnt[1], 4);
    chk("fill_err", 1, smp_err[1], 1'b0);
    down_rdy[1] = 1'b1;
    step();
    chk("rdy_at_first_pop", 1, smp_rdy[1], 1'b0);
    chk("first_pop_data", 1, smp_dat[1], 32'h100);
    pops = int'(ev_pop[1]);
    step();
    chk("rdy_after_pop", 1, smp_rdy[1], 1'b1);
    pops += int'(ev_pop[1]);
    for (int i = 0; i < 6; i++) begin
      step();
      pops += int'(ev_pop[1]);
    end
    chk("drain_pops", 1, pops, 4);
    down_rdy[1] = 1'b0;

    // 4. Streaming 100 results
    down_rdy[0] = 1'b1;
    drops = 0; maxc = 0; dvn = 0; pops = 0; dv4 = 1'b1;
    for (int i = 0; i < 110; i++) begin
      up_vld[0]  = (i < 100);
      arg_val[0] = 32'(i + 1);
      step();
      if (i < 100 && !smp_rdy[0]) drops++;
      if (smp_cnt[0] > maxc) maxc = smp_cnt[0];
      if (i == 4) dv4 = smp_dv[0];
      if (i >= 5 && i < 105 && smp_dv[0]) dvn++;
      if (ev_pop[0]) pops++;
    end
    chk("stream_rdy_drops", 0, drops, 0);
    chk("stream_max_count", 0, maxc, 1);
    chk("stream_dv_c4", 0, dv4, 1'b0);
    chk("stream_dv_cont", 0, dvn, 100);
    chk("stream_pops", 0, pops, 100);

    // 5. Random stalls across pointer wrap
    issued = 0; pops = 0;
    for (int i = 0; i < 600 && pops < 20; i++) begin
      up_vld[0]   = (issued < 20) && ($urandom_range(0, 3) != 0);
      arg_val[0]  = $urandom;
      down_rdy[0] = ($urandom_range(0, 2) == 0);
      step();
      if (ev_iss[0]) issued++;
      if (ev_pop[0]) pops++;
    end
    up_vld[0] = 1'b0; down_rdy[0] = 1'b0;
    step();
    chk("wrap_pops", 0, pops, 20);
    chk("wrap_err", 0, smp_err[0], 1'b0);

    // 6. Spurious result, then mid-operation reset with 3 queued
    up_vld[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      arg_val[0] = 32'h600 + 32'(i);
      step();
    end
    up_vld[0] = 1'b0;
    repeat (6) step();
    chk("err_pre_count", 0, smp_cnt[0], 3);
    inj[0] = 1'b1;
    step();
    inj[0] = 1'b0;
    chk("err_pre_err", 0, smp_err[0], 1'b0);
    step();
    chk("err_set", 0, smp_err[0], 1'b1);
    chk("err_count_kept", 0, smp_cnt[0], 3);
    repeat (3) step();
    chk("err_sticky", 0, smp_err[0], 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_count", 0, smp_cnt[0], 0);
    chk("mid_rst_err", 0, smp_err[0], 1'b0);
    chk("mid_rst_down_vld", 0, smp_dv[0], 1'b0);
    chk("mid_rst_up_rdy", 0, smp_rdy[0], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
